// File: rtl/stack_ctrl.sv
// Data-stack sequencer for the stack CPU: TOS held in a register, deeper entries
// spilled to / filled from a single-port RAM with one cycle of read latency.
module stack_ctrl #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [WIDTH-1:0]  req_data,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_data,
  output logic [WIDTH-1:0]  tos_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              err_ovf,
  output logic              err_unf,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_re,
  output logic [WIDTH-1:0]  ram_wdata,
  input  logic [WIDTH-1:0]  ram_rdata
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);
  localparam logic [1:0] OP_PUSH    = 2'b01;
  localparam logic [1:0] OP_POP     = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

  typedef enum logic [1:0] {IDLE, SPILL, FILL_RD, FILL_WAIT} state_t;

  state_t           state;
  logic [WIDTH-1:0] tos_reg;
  logic [WIDTH-1:0] push_data;
  logic             accept;
  logic             ovf_evt;
  logic             unf_evt;

  assign req_ready = (state == IDLE) && !clr;
  assign accept    = req_valid && req_ready;
  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign tos_data  = tos_reg;
  assign ovf_evt   = accept && (req_op == OP_PUSH) && full;
  assign unf_evt   = accept && (req_op == OP_POP || req_op == OP_REPLACE) && empty;

  // clr gates the strobes so an aborted spill/fill never touches the RAM
  assign ram_we = (state == SPILL) && !clr;
  assign ram_re = (state == FILL_RD) && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      tos_reg   <= '0;
      push_data <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      // a same-cycle error event overrides clr_err
      err_ovf   <= (err_ovf && !clr_err) || ovf_evt;
      err_unf   <= (err_unf && !clr_err) || unf_evt;
      if (clr) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              case (req_op)
                OP_PUSH: begin
                  if (!full) begin
                    if (empty) begin
                      tos_reg <= req_data;
                      count   <= ONE_C;
                    end else begin
                      push_data <= req_data;
                      ram_addr  <= ADDR_W'(count - ONE_C);
                      ram_wdata <= tos_reg;
                      state     <= SPILL;
                    end
                  end
                end
                OP_POP: begin
                  if (!empty) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= tos_reg;
                    if (count == ONE_C) begin
                      count <= '0;
                    end else begin
                      ram_addr <= ADDR_W'(count - (ADDR_W+1)'(2));
                      state    <= FILL_RD;
                    end
                  end
                end
                OP_REPLACE: begin
                  if (!empty) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= tos_reg;
                    tos_reg   <= req_data;
                  end
                end
                default: ;
              endcase
            end
          end
          SPILL: begin
            tos_reg <= push_data;
            count   <= count + ONE_C;
            state   <= IDLE;
          end
          FILL_RD: state <= FILL_WAIT;
          FILL_WAIT: begin
            tos_reg <= ram_rdata;
            count   <= count - ONE_C;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed vector table, hand-written corner sequences,
// and randomized ops checked against a queue-based stack model.
module tb_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [15:0] req_data = 16'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [15:0] tos_data;
  logic [5:0]  count;
  logic        empty, full, err_ovf, err_unf;
  logic        clr_err = 1'b0;
  logic [4:0]  ram_addr;
  logic        ram_we, ram_re;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = 16'h0;

  stack_ctrl #(.WIDTH(16), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .clr(clr), .req_valid(req_valid), .req_op(req_op),
    .req_data(req_data), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .tos_data(tos_data), .count(count), .empty(empty),
    .full(full), .err_ovf(err_ovf), .err_unf(err_unf), .clr_err(clr_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_re(ram_re),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM with one cycle of read latency
  logic [15:0] mem [32];
  int          nwr = 0;
  logic [4:0]  last_waddr = '0, last_raddr = '0;
  logic [15:0] last_wdata = '0;
  logic        both_seen = 1'b0;
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      nwr        <= nwr + 1;
      last_waddr <= ram_addr;
      last_wdata <= ram_wdata;
    end
    if (ram_re) begin
      ram_rdata  <= mem[ram_addr];
      last_raddr <= ram_addr;
    end
    if (ram_we && ram_re) both_seen <= 1'b1;
  end

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; req_valid = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // one request; returns cycles until ready again, rsp pulses seen and last rsp value
  task automatic apply(input logic [1:0] op, input logic [15:0] d, input logic ce,
                       output int cyc, output int nrsp, output logic [15:0] rd);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_data = d; clr_err = ce;
    cyc = 0; nrsp = 0; rd = 16'h0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 2'b00; clr_err = 1'b0;
    cyc = 1;
    if (rsp_valid) begin nrsp++; rd = rsp_data; end
    while (!req_ready && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (rsp_valid) begin nrsp++; rd = rsp_data; end
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] d;
    logic        ce;
    int          cyc;
    logic        rv;
    logic [15:0] rd;
    int          cnt;
    logic [15:0] tos;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t tbl [12];

  // behavioural model
  logic [15:0] q[$];
  logic        m_ovf, m_unf;

  initial begin
    int cyc, nrsp;
    logic [15:0] rd;
    int w0;

    tbl[0]  = '{2'b01, 16'h0001, 1'b0, 1, 1'b0, 16'h0000, 1, 16'h0001, 1'b0, 1'b0};
    tbl[1]  = '{2'b10, 16'h0000, 1'b0, 1, 1'b1, 16'h0001, 0, 16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{2'b10, 16'h0000, 1'b0, 1, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 1'b1};
    tbl[3]  = '{2'b01, 16'h00AA, 1'b1, 1, 1'b0, 16'h0000, 1, 16'h00AA, 1'b0, 1'b0};
    tbl[4]  = '{2'b01, 16'h00BB, 1'b0, 2, 1'b0, 16'h0000, 2, 16'h00BB, 1'b0, 1'b0};
    tbl[5]  = '{2'b10, 16'h0000, 1'b0, 3, 1'b1, 16'h00BB, 1, 16'h00AA, 1'b0, 1'b0};
    tbl[6]  = '{2'b01, 16'h0005, 1'b0, 2, 1'b0, 16'h0000, 2, 16'h0005, 1'b0, 1'b0};
    tbl[7]  = '{2'b11, 16'h1234, 1'b0, 1, 1'b1, 16'h0005, 2, 16'h1234, 1'b0, 1'b0};
    tbl[8]  = '{2'b00, 16'hFFFF, 1'b0, 1, 1'b0, 16'h0000, 2, 16'h1234, 1'b0, 1'b0};
    tbl[9]  = '{2'b10, 16'h0000, 1'b0, 3, 1'b1, 16'h1234, 1, 16'h00AA, 1'b0, 1'b0};
    tbl[10] = '{2'b10, 16'h0000, 1'b0, 1, 1'b1, 16'h00AA, 0, 16'h0000, 1'b0, 1'b0};
    tbl[11] = '{2'b11, 16'h7777, 1'b0, 1, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 1'b1};

    // reset values while rst held
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_tos", tos_data, 0);
    chk("rst_ram_strobes", {ram_we, ram_re}, 0);
    do_reset();

    foreach (tbl[i]) begin
      apply(tbl[i].op, tbl[i].d, tbl[i].ce, cyc, nrsp, rd);
      chk($sformatf("tbl%0d_cycles", i), cyc, tbl[i].cyc);
      chk($sformatf("tbl%0d_rsp_count", i), nrsp, tbl[i].rv);
      if (tbl[i].rv) chk($sformatf("tbl%0d_rsp_data", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      if (tbl[i].cnt > 0) chk($sformatf("tbl%0d_tos", i), tos_data, tbl[i].tos);
      chk($sformatf("tbl%0d_errs", i), {err_ovf, err_unf}, {tbl[i].ovf, tbl[i].unf});
    end

    // single push never writes RAM; second push spills old TOS to addr 0
    do_reset();
    w0 = nwr;
    apply(2'b01, 16'h0001, 1'b0, cyc, nrsp, rd);
    chk("t1_no_ram_we", nwr - w0, 0);
    apply(2'b01, 16'h00BB, 1'b0, cyc, nrsp, rd);
    chk("t2_spill_addr", last_waddr, 0);
    chk("t2_spill_data", last_wdata, 16'h0001);
    apply(2'b10, 16'h0000, 1'b0, cyc, nrsp, rd);
    chk("t2_fill_addr", last_raddr, 0);

    // fill to capacity, overflow, clr_err vs same-cycle event
    do_reset();
    for (int i = 0; i < 32; i++) apply(2'b01, 16'h0100 + 16'(i), 1'b0, cyc, nrsp, rd);
    chk("t3_count_full", count, 32);
    chk("t3_full", full, 1);
    apply(2'b01, 16'hDEAD, 1'b0, cyc, nrsp, rd);
    chk("t3_ovf", err_ovf, 1);
    chk("t3_ovf_cycles", cyc, 1);
    chk("t3_ovf_count", count, 32);
    chk("t3_ovf_tos", tos_data, 16'h011F);
    apply(2'b01, 16'hBEEF, 1'b1, cyc, nrsp, rd);
    chk("t3_err_wins", err_ovf, 1);
    apply(2'b00, 16'h0000, 1'b1, cyc, nrsp, rd);
    chk("t3_clr_err", err_ovf, 0);

    // clr during SPILL
    do_reset();
    apply(2'b01, 16'h0011, 1'b0, cyc, nrsp, rd);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_data = 16'h0022;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 2'b00; clr = 1'b1;
    w0 = nwr;
    #1;
    chk("t5_we_gated", ram_we, 0);
    chk("t5_ready_low", req_ready, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    chk("t5_no_write", nwr - w0, 0);
    chk("t5_count", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_ready", req_ready, 1);
    apply(2'b01, 16'h0033, 1'b0, cyc, nrsp, rd);
    chk("t5_push_after", {10'(count), tos_data}, {10'd1, 16'h0033});

    // rst during FILL_WAIT
    do_reset();
    apply(2'b01, 16'h0A01, 1'b0, cyc, nrsp, rd);
    apply(2'b01, 16'h0A02, 1'b0, cyc, nrsp, rd);
    apply(2'b01, 16'h0A03, 1'b0, cyc, nrsp, rd);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_count", count, 0);
    chk("t6_tos", tos_data, 0);
    chk("t6_rsp", {rsp_valid, rsp_data}, 0);
    chk("t6_ram", {ram_we, ram_re, ram_addr, ram_wdata}, 0);
    chk("t6_errs", {err_ovf, err_unf}, 0);
    chk("t6_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    apply(2'b01, 16'h4242, 1'b0, cyc, nrsp, rd);
    chk("t6_push_after", {10'(count), tos_data}, {10'd1, 16'h4242});

    // randomized ops against the queue model
    do_reset();
    q.delete();
    m_ovf = 1'b0; m_unf = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic [1:0]  op;
      logic [15:0] d;
      logic        ce, ev_o, ev_u, exp_rv;
      logic [15:0] exp_rd;
      int          exp_cyc, r;
      r  = $urandom_range(0, 99);
      d  = 16'($urandom);
      ce = ($urandom_range(0, 9) == 0);
      if (((n / 100) % 2) == 0)
        op = (r < 60) ? 2'b01 : (r < 80) ? 2'b10 : (r < 92) ? 2'b11 : 2'b00;
      else
        op = (r < 60) ? 2'b10 : (r < 80) ? 2'b01 : (r < 92) ? 2'b11 : 2'b00;
      ev_o = 1'b0; ev_u = 1'b0; exp_rv = 1'b0; exp_rd = 16'h0; exp_cyc = 1;
      case (op)
        2'b01: if (q.size() == 32) ev_o = 1'b1;
               else begin
                 if (q.size() > 0) exp_cyc = 2;
                 q.push_back(d);
               end
        2'b10: if (q.size() == 0) ev_u = 1'b1;
               else begin
                 if (q.size() > 1) exp_cyc = 3;
                 exp_rv = 1'b1; exp_rd = q.pop_back();
               end
        2'b11: if (q.size() == 0) ev_u = 1'b1;
               else begin
                 exp_rv = 1'b1; exp_rd = q[q.size()-1];
                 q[q.size()-1] = d;
               end
        default: ;
      endcase
      m_ovf = (m_ovf && !ce) || ev_o;
      m_unf = (m_unf && !ce) || ev_u;
      apply(op, d, ce, cyc, nrsp, rd);
      chk($sformatf("rnd%0d_cycles", n), cyc, exp_cyc);
      chk($sformatf("rnd%0d_rsp_count", n), nrsp, exp_rv);
      if (exp_rv) chk($sformatf("rnd%0d_rsp_data", n), rd, exp_rd);
      chk($sformatf("rnd%0d_count", n), count, q.size());
      chk($sformatf("rnd%0d_flags", n), {empty, full}, {q.size() == 0, q.size() == 32});
      if (q.size() > 0) chk($sformatf("rnd%0d_tos", n), tos_data, q[q.size()-1]);
      chk($sformatf("rnd%0d_errs", n), {err_ovf, err_unf}, {m_ovf, m_unf});
    end

    chk("ram_we_re_exclusive", both_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
